// File: rtl/rib_mem_arbiter.sv
// rib_mem_arbiter: shares one slave bus port between fetch, data and debug
// masters using non-preemptive fixed priority, and generates the pipeline hold
// flag. Only one transfer is outstanding at any time. A transfer that never
// receives s_ack_i ends with an error completion after TIMEOUT busy cycles.
module rib_mem_arbiter #(
  parameter int N_MASTER = 3,
  parameter int TIMEOUT  = 16,
  parameter int GW       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MASTER-1:0]      m_req_i,
  input  logic [N_MASTER-1:0]      m_we_i,
  input  logic [32*N_MASTER-1:0]   m_addr_i,
  input  logic [32*N_MASTER-1:0]   m_wdata_i,
  output logic [N_MASTER-1:0]      m_ack_o,
  output logic [N_MASTER-1:0]      m_err_o,
  output logic [31:0]              rdata_o,
  output logic                     s_req_o,
  output logic                     s_we_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  input  logic [31:0]              s_rdata_i,
  input  logic                     s_ack_i,
  output logic [2:0]               hold_flag_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_EX   = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         pick;
  logic [CW-1:0]         cnt;
  logic                  any_req;
  logic                  high_req;
  logic                  timed_out;
  logic [N_MASTER-1:0]   grant_onehot;
  logic                  sel_we;
  logic [31:0]           sel_addr;
  logic [31:0]           sel_wdata;

  assign any_req      = |m_req_i;
  assign high_req     = |m_req_i[N_MASTER-1:1];
  assign timed_out    = (cnt == CNT_LAST);
  assign grant_onehot = {{(N_MASTER-1){1'b0}}, 1'b1} << grant;
  assign s_req_o      = (state == BUSY);

  // Fixed priority: the highest-indexed active request wins.
  always_comb begin
    pick = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (m_req_i[k]) begin
        pick = GW'(k);
      end
    end
  end

  // Select the winning master's write enable, address and write data.
  always_comb begin
    sel_we    = m_we_i[pick];
    sel_addr  = m_addr_i[32*pick +: 32];
    sel_wdata = m_wdata_i[32*pick +: 32];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: DONE always returns to IDLE so nothing is granted in it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (s_ack_i || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pipeline hold: data/debug activity freezes EX, fetch-only activity freezes IF.
  always_comb begin
    hold_flag_o = HOLD_NONE;
    if (state != DONE) begin
      if (high_req || (state == BUSY && grant != '0)) begin
        hold_flag_o = HOLD_EX;
      end else if (m_req_i[0] || (state == BUSY && grant == '0)) begin
        hold_flag_o = HOLD_IF;
      end
    end
  end

  // Transfer datapath: latch the granted request, count wait cycles, and
  // produce the one-cycle completion (or timeout error) pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant     <= '0;
      cnt       <= '0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      rdata_o   <= '0;
      m_ack_o   <= '0;
      m_err_o   <= '0;
    end else begin
      m_ack_o <= '0;
      m_err_o <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            s_we_o    <= sel_we;
            s_addr_o  <= sel_addr;
            s_wdata_o <= sel_wdata;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (s_ack_i) begin
            rdata_o <= s_rdata_i;
            m_ack_o <= grant_onehot;
          end else if (timed_out) begin
            rdata_o <= '0;
            m_ack_o <= grant_onehot;
            m_err_o <= grant_onehot;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rib_mem_arbiter.sv
// Testbench for rib_mem_arbiter: directed transactions with a scoreboard of
// expected completions that a separate monitor pops whenever an ack appears.
module tb_rib_mem_arbiter;

  logic         clk;
  logic         rst;
  logic [2:0]   m_req_i;
  logic [2:0]   m_we_i;
  logic [95:0]  m_addr_i;
  logic [95:0]  m_wdata_i;
  logic [2:0]   m_ack_o;
  logic [2:0]   m_err_o;
  logic [31:0]  rdata_o;
  logic         s_req_o;
  logic         s_we_o;
  logic [31:0]  s_addr_o;
  logic [31:0]  s_wdata_o;
  logic [31:0]  s_rdata_i;
  logic         s_ack_i;
  logic [2:0]   hold_flag_o;

  typedef struct {
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   failed   = 0;
  int   cyc      = 0;

  rib_mem_arbiter #(.N_MASTER(3), .TIMEOUT(16), .GW(2)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .rdata_o(rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .hold_flag_o(hold_flag_o)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic ack, input logic [31:0] srd);
    m_req_i   = req;
    s_ack_i   = ack;
    s_rdata_i = srd;
  endtask

  task automatic pushExpect(input logic [2:0] ack, input logic [2:0] err, input logic [31:0] rd, input int c);
    exp_t e;
    e.ack = ack; e.err = err; e.rdata = rd; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (m_ack_o !== 3'b000 || m_err_o !== 3'b000) begin
      if (sb.size() == 0) begin
        compared++;
        failed++;
        $display("[TB] FAIL unexpected_ack: got ack %b err %b required none", m_ack_o, m_err_o);
      end else begin
        e = sb.pop_front();
        checkOutput("m_ack_o", {29'd0, m_ack_o}, {29'd0, e.ack});
        checkOutput("m_err_o", {29'd0, m_err_o}, {29'd0, e.err});
        checkOutput("rdata_o", rdata_o, e.rdata);
        checkOutput("ack_cycle", cyc, e.cyc);
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [2:0]  req_tab  [9];
  logic        ack_tab  [9];
  logic [2:0]  hold_tab [9];
  logic [31:0] rd_tab   [9];
  logic [31:0] addr_tab [9];
  int          c0;

  initial begin
    rst       = 1'b0;
    m_req_i   = '0;
    m_we_i    = '0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    s_rdata_i = '0;
    s_ack_i   = 1'b0;

    // Reset values.
    step();
    @(negedge clk);
    checkOutput("rst_s_req", {31'd0, s_req_o}, 32'd0);
    checkOutput("rst_s_we", {31'd0, s_we_o}, 32'd0);
    checkOutput("rst_s_addr", s_addr_o, 32'd0);
    checkOutput("rst_s_wdata", s_wdata_o, 32'd0);
    checkOutput("rst_rdata", rdata_o, 32'd0);
    checkOutput("rst_m_ack", {29'd0, m_ack_o}, 32'd0);
    checkOutput("rst_m_err", {29'd0, m_err_o}, 32'd0);
    checkOutput("rst_hold", {29'd0, hold_flag_o}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Data write, zero wait states.
    $display("[TB] data write, zero wait");
    c0 = cyc;
    m_we_i = 3'b010;
    m_addr_i[63:32]  = 32'h0000_1000;
    m_wdata_i[63:32] = 32'hDEAD_BEEF;
    pushExpect(3'b010, 3'b000, 32'hA5A5_0001, c0 + 2);
    applyStimulus(3'b010, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_hold_c0", {29'd0, hold_flag_o}, 32'd4);
    step();
    applyStimulus(3'b010, 1'b1, 32'hA5A5_0001);
    @(negedge clk);
    checkOutput("t1_s_req_c1", {31'd0, s_req_o}, 32'd1);
    checkOutput("t1_s_we_c1", {31'd0, s_we_o}, 32'd1);
    checkOutput("t1_s_addr_c1", s_addr_o, 32'h0000_1000);
    checkOutput("t1_s_wdata_c1", s_wdata_o, 32'hDEAD_BEEF);
    checkOutput("t1_hold_c1", {29'd0, hold_flag_o}, 32'd4);
    step();
    applyStimulus(3'b010, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_hold_c2", {29'd0, hold_flag_o}, 32'd0);
    checkOutput("t1_s_req_c2", {31'd0, s_req_o}, 32'd0);
    step();
    applyStimulus(3'b000, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t1_s_req_c3", {31'd0, s_req_o}, 32'd0);
    checkOutput("t1_hold_c3", {29'd0, hold_flag_o}, 32'd0);
    step();

    // Contention: debug, then data, then fetch.
    $display("[TB] contention");
    m_we_i = 3'b000;
    m_addr_i  = {32'h0000_3000, 32'h0000_2000, 32'h0000_0100};
    m_wdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    req_tab  = '{3'b111, 3'b111, 3'b111, 3'b011, 3'b011, 3'b011, 3'b001, 3'b001, 3'b001};
    ack_tab  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    hold_tab = '{3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd0, 3'd2, 3'd2, 3'd0};
    rd_tab   = '{32'hFFFF_FFFF, 32'hC0DE_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hC0DE_0001,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hC0DE_0000, 32'hFFFF_FFFF};
    addr_tab = '{32'h0, 32'h0000_3000, 32'h0, 32'h0, 32'h0000_2000, 32'h0, 32'h0, 32'h0000_0100, 32'h0};
    c0 = cyc;
    pushExpect(3'b100, 3'b000, 32'hC0DE_0002, c0 + 2);
    pushExpect(3'b010, 3'b000, 32'hC0DE_0001, c0 + 5);
    pushExpect(3'b001, 3'b000, 32'hC0DE_0000, c0 + 8);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(req_tab[i], ack_tab[i], rd_tab[i]);
      @(negedge clk);
      checkOutput($sformatf("t2_hold_c%0d", i), {29'd0, hold_flag_o}, {29'd0, hold_tab[i]});
      if (ack_tab[i]) begin
        checkOutput($sformatf("t2_s_addr_c%0d", i), s_addr_o, addr_tab[i]);
        checkOutput($sformatf("t2_s_req_c%0d", i), {31'd0, s_req_o}, 32'd1);
      end
      step();
    end

    // Wait-state fetch read with the master address changing mid-transfer.
    $display("[TB] wait-state read");
    m_addr_i = '0;
    m_addr_i[31:0] = 32'h0000_0080;
    c0 = cyc;
    pushExpect(3'b001, 3'b000, 32'h1234_5678, c0 + 5);
    for (int i = 0; i < 7; i++) begin
      if (i == 2) m_addr_i[31:0] = 32'hFFFF_0000;
      applyStimulus((i < 6) ? 3'b001 : 3'b000, (i == 4), (i == 4) ? 32'h1234_5678 : 32'h0BAD_0BAD);
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        checkOutput($sformatf("t3_s_addr_c%0d", i), s_addr_o, 32'h0000_0080);
        checkOutput($sformatf("t3_s_req_c%0d", i), {31'd0, s_req_o}, 32'd1);
      end
      step();
    end

    // Stray acks while idle must be ignored.
    $display("[TB] stray ack");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b000, 1'b1, 32'hBAD0_BAD0);
      @(negedge clk);
      checkOutput($sformatf("t6_m_ack_c%0d", i), {29'd0, m_ack_o}, 32'd0);
      checkOutput($sformatf("t6_rdata_c%0d", i), rdata_o, 32'h1234_5678);
      checkOutput($sformatf("t6_s_req_c%0d", i), {31'd0, s_req_o}, 32'd0);
      step();
    end

    // Timeout on a data read that the slave never acknowledges.
    $display("[TB] timeout");
    m_addr_i[63:32] = 32'h0000_2000;
    c0 = cyc;
    pushExpect(3'b010, 3'b010, 32'h0, c0 + 17);
    for (int i = 0; i < 19; i++) begin
      applyStimulus((i < 18) ? 3'b010 : 3'b000, 1'b0, 32'h5555_AAAA);
      @(negedge clk);
      if (i >= 1) begin
        checkOutput($sformatf("t4_s_req_c%0d", i), {31'd0, s_req_o}, (i <= 16) ? 32'd1 : 32'd0);
      end
      if (i == 18) begin
        checkOutput("t4_hold_idle", {29'd0, hold_flag_o}, 32'd0);
      end
      step();
    end

    // Asynchronous reset during BUSY abandons the transfer.
    $display("[TB] async reset");
    m_we_i = 3'b100;
    m_addr_i[95:64] = 32'h0000_3000;
    applyStimulus(3'b100, 1'b0, 32'h0);
    step();
    @(negedge clk);
    checkOutput("t5_s_req_busy", {31'd0, s_req_o}, 32'd1);
    #2;
    rst = 1'b0;
    m_req_i = 3'b000;
    #1;
    checkOutput("t5_s_req_rst", {31'd0, s_req_o}, 32'd0);
    checkOutput("t5_m_ack_rst", {29'd0, m_ack_o}, 32'd0);
    checkOutput("t5_hold_rst", {29'd0, hold_flag_o}, 32'd0);
    checkOutput("t5_s_addr_rst", s_addr_o, 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b000, 1'b1, 32'h7777_7777);
      @(negedge clk);
      checkOutput($sformatf("t5_m_ack_post_c%0d", i), {29'd0, m_ack_o}, 32'd0);
      checkOutput($sformatf("t5_rdata_post_c%0d", i), rdata_o, 32'd0);
      step();
    end
    applyStimulus(3'b000, 1'b0, 32'h0);
    step();
    step();

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/rib_mem_arbiter.md
Name: rib_mem_arbiter

Overview:
- Sequences and shares the single memory/peripheral bus port between N masters: instruction fetch, the data access from the ex/mem stage, and debug.
- Non-preemptive fixed-priority arbitration; one outstanding transfer at a time.
- Generates the pipeline hold flag so upstream pipeline registers freeze while a data/debug access is pending.
- Sits between the core pipeline (hold_flag consumers) and the slave-side bus.

Parameters:
- N_MASTER, 3, number of masters; index 0 = fetch, 1 = data, 2 = debug; higher index wins.
- TIMEOUT, 16, maximum BUSY cycles waiting for s_ack_i before an error completion (≥2).
- GW, 2, grant index width (≥ clog2(N_MASTER)).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_req_i  in  N_MASTER  per-master request; held high until that master sees m_ack_o.
- m_we_i  in  N_MASTER  per-master write enable.
- m_addr_i  in  32*N_MASTER  per-master address; master k at [32k+31:32k].
- m_wdata_i  in  32*N_MASTER  per-master write data, same packing.
- m_ack_o  out  N_MASTER  one-cycle completion pulse to the granted master.
- m_err_o  out  N_MASTER  one-cycle timeout error, coincident with m_ack_o.
- rdata_o  out  32  read data, valid when any m_ack_o bit is high.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  32  slave address.
- s_wdata_o  out  32  slave write data.
- s_rdata_i  in  32  slave read data, sampled with s_ack_i.
- s_ack_i  in  1  slave completion.
- hold_flag_o  out  3  pipeline hold: 0 = Hold_None, 2 = Hold_If, 4 = Hold_Ex.

Behaviour:
- States: IDLE, BUSY, DONE (registered).
- Reset (rst low, async): state IDLE; grant 0; timeout counter 0; s_req_o, s_we_o, m_ack_o, m_err_o = 0; s_addr_o, s_wdata_o, rdata_o = 0. hold_flag_o is then 0 whenever all m_req_i are low.
- IDLE:
  - If any m_req_i bit is set, grant the highest set index.
  - Register that master's we, addr and wdata into the s_* outputs.
  - Clear the timeout counter and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - s_req_o = 1; s_we_o, s_addr_o and s_wdata_o hold their registered values. Master inputs changing here have no effect.
  - If s_ack_i: capture s_rdata_i into rdata_o (also on writes), set m_ack_o[grant] for the next cycle, go to DONE.
  - Otherwise, if the counter equals TIMEOUT-1: rdata_o = 0, set m_ack_o[grant] and m_err_o[grant], go to DONE.
  - Otherwise increment the counter.
  - If s_ack_i and the timeout coincide, the ack wins and no error is raised.
- DONE:
  - Lasts exactly one cycle; s_req_o = 0; m_ack_o/m_err_o pulse visible.
  - No arbitration in this cycle, so a master dropping its request after seeing ack is never re-granted.
  - Go to IDLE.
- Latency: request sampled at edge 0; s_req_o high from cycle 1; earliest m_ack_o is cycle 2. Back-to-back grants are spaced by a minimum of 3 cycles.
- s_ack_i in IDLE or DONE is ignored.
- hold_flag_o (combinational from state, grant and m_req_i):
  - DONE: 0.
  - Otherwise 4 if any m_req_i[k] with k≥1 is high, or the state is BUSY with grant≥1.
  - Otherwise 2 if m_req_i[0] is high or the state is BUSY with grant 0.
  - Otherwise 0.
- Reset mid-transfer: the access is abandoned, outputs clear immediately, no ack is issued.

Test Plan:
- Data write, zero wait: m_req_i=3'b010, addr 0x0000_1000, wdata 0xDEADBEEF at cycle 0, s_ack_i=1 in cycle 1 -> s_req_o=1 with s_addr_o=0x1000 and s_wdata_o=0xDEADBEEF in cycle 1; m_ack_o=3'b010 in cycle 2; hold_flag_o=4 in cycles 0–1 and 0 in cycle 2.
- Contention: m_req_i=3'b111 held, each slave acks after 1 cycle, each master drops its request on ack -> grants in order 2, 1, 0; m_ack_o pulses 3'b100, 3'b010, 3'b001 at cycles 2, 5, 8; hold_flag_o=4 until the debug and data accesses complete, then 2 during the fetch.
- Wait-state read: fetch read of 0x80, s_ack_i after 3 BUSY cycles with s_rdata_i=0x1234_5678, m_addr_i[31:0] changed mid-BUSY -> s_addr_o stays 0x80; rdata_o=0x12345678 with m_ack_o=3'b001; m_err_o=0.
- Timeout: TIMEOUT=16, data read, s_ack_i never asserted -> s_req_o high in cycles 1–16; m_ack_o[1]=m_err_o[1]=1 and rdata_o=0 in cycle 17; state returns to IDLE.
- Async reset: drive rst low during BUSY -> s_req_o, m_ack_o and hold_flag_o go to 0 without a clock edge; s_ack_i asserted after reset release gives no m_ack_o.
- Stray ack: s_ack_i=1 with all requests low for 5 cycles -> m_ack_o=0, rdata_o unchanged, state stays IDLE.
